// File: rtl/axil_cmd_master.sv
// Byte-stream command frames in, single AXI4-Lite read/write out, response frame back.
// Frames: opcode, 4 address bytes, (4 data bytes for writes), all little-endian.
`timescale 1ns/1ps
module axil_cmd_master #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int FRAME_TIMEOUT  = 1000000
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [7:0]                  cmd_data_i,
    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    output logic [7:0]                  rsp_data_o,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic                        busy_o,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                  m_axi_awprot,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [3:0]                  m_axi_wstrb,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    input  logic [1:0]                  m_axi_bresp,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]                  m_axi_arprot,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready
);

    localparam logic [7:0]  OP_READ       = 8'h01;
    localparam logic [7:0]  OP_WRITE      = 8'h02;
    localparam logic [7:0]  RSP_BAD_OP    = 8'hEE;
    localparam logic [31:0] TIMEOUT_LIMIT = 32'(FRAME_TIMEOUT);
    localparam int          RSP_W         = AXI_DATA_WIDTH + 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_AW_W,
        S_B,
        S_AR,
        S_R,
        S_RSP
    } state_t;

    state_t                     state_q,     state_d;
    logic                       is_write_q,  is_write_d;
    logic [1:0]                 byte_cnt_q,  byte_cnt_d;
    logic [AXI_ADDR_WIDTH-1:0]  addr_q,      addr_d;
    logic [AXI_DATA_WIDTH-1:0]  wdata_q,     wdata_d;
    logic [RSP_W-1:0]           rsp_buf_q,   rsp_buf_d;
    logic [2:0]                 rsp_left_q,  rsp_left_d;
    logic [31:0]                idle_cnt_q,  idle_cnt_d;
    logic                       aw_done_q,   aw_done_d;
    logic                       w_done_q,    w_done_d;

    logic cmd_fire;
    logic rsp_fire;

    assign cmd_ready_o   = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_DATA);
    assign rsp_valid_o   = (state_q == S_RSP);
    // The response buffer shifts right per sent byte, so the current byte is always the LSB.
    assign rsp_data_o    = rsp_buf_q[7:0];
    assign busy_o        = (state_q != S_IDLE);

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = (state_q == S_AW_W) && !aw_done_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = (state_q == S_AW_W) && !w_done_q;
    assign m_axi_bready  = (state_q == S_B);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = (state_q == S_AR);
    assign m_axi_rready  = (state_q == S_R);

    assign cmd_fire = cmd_valid_i && cmd_ready_o;
    assign rsp_fire = rsp_valid_o && rsp_ready_i;

    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        byte_cnt_d = byte_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rsp_buf_d  = rsp_buf_q;
        rsp_left_d = rsp_left_q;
        idle_cnt_d = idle_cnt_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    if ((cmd_data_i == OP_READ) || (cmd_data_i == OP_WRITE)) begin
                        is_write_d = (cmd_data_i == OP_WRITE);
                        byte_cnt_d = 2'd0;
                        idle_cnt_d = 32'd0;
                        state_d    = S_ADDR;
                    end else begin
                        rsp_buf_d  = {{AXI_DATA_WIDTH{1'b0}}, RSP_BAD_OP};
                        rsp_left_d = 3'd1;
                        state_d    = S_RSP;
                    end
                end
            end

            S_ADDR, S_DATA: begin
                if (cmd_fire) begin
                    idle_cnt_d = 32'd0;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (state_q == S_ADDR) begin
                        addr_d[{byte_cnt_q, 3'b000} +: 8] = cmd_data_i;
                    end else begin
                        wdata_d[{byte_cnt_q, 3'b000} +: 8] = cmd_data_i;
                    end
                    if (byte_cnt_q == 2'd3) begin
                        if (state_q == S_DATA) begin
                            aw_done_d = 1'b0;
                            w_done_d  = 1'b0;
                            state_d   = S_AW_W;
                        end else begin
                            state_d   = is_write_q ? S_DATA : S_AR;
                        end
                    end
                end else if (TIMEOUT_LIMIT != 32'd0) begin
                    // A stalled host loses its partial frame without any response.
                    if (idle_cnt_q + 32'd1 == TIMEOUT_LIMIT) begin
                        idle_cnt_d = 32'd0;
                        state_d    = S_IDLE;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 32'd1;
                    end
                end
            end

            S_AW_W: begin
                aw_done_d = aw_done_q || m_axi_awready;
                w_done_d  = w_done_q  || m_axi_wready;
                if (aw_done_d && w_done_d) begin
                    state_d = S_B;
                end
            end

            S_B: begin
                if (m_axi_bvalid) begin
                    rsp_buf_d  = {{AXI_DATA_WIDTH{1'b0}}, 4'hA, 2'b00, m_axi_bresp};
                    rsp_left_d = 3'd1;
                    state_d    = S_RSP;
                end
            end

            S_AR: begin
                if (m_axi_arready) begin
                    state_d = S_R;
                end
            end

            S_R: begin
                if (m_axi_rvalid) begin
                    rsp_buf_d  = {m_axi_rdata, 4'hA, 2'b00, m_axi_rresp};
                    rsp_left_d = 3'd5;
                    state_d    = S_RSP;
                end
            end

            S_RSP: begin
                if (rsp_fire) begin
                    rsp_buf_d  = rsp_buf_q >> 8;
                    rsp_left_d = rsp_left_q - 3'd1;
                    if (rsp_left_q == 3'd1) begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            is_write_q <= 1'b0;
            byte_cnt_q <= 2'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_buf_q  <= '0;
            rsp_left_q <= 3'd0;
            idle_cnt_q <= 32'd0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            byte_cnt_q <= byte_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rsp_buf_q  <= rsp_buf_d;
            rsp_left_q <= rsp_left_d;
            idle_cnt_q <= idle_cnt_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master: scoreboarded response bytes plus a simple AXI4-Lite slave.
`timescale 1ns/1ps
module tb_axil_cmd_master;

    logic        clk;
    logic        rst_ni;
    logic [7:0]  cmd_data_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [7:0]  rsp_data_o;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic        busy_o;
    logic [31:0] m_axi_awaddr;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [31:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    int bp_mode = 0;
    int aw_wait = 0;
    int w_wait  = 0;
    int r_wait  = 0;
    logic [31:0] rdata_cfg = 32'h0;
    logic [1:0]  rresp_cfg = 2'b00;
    logic [1:0]  bresp_cfg = 2'b00;

    logic [31:0] cap_awaddr = 32'h0;
    logic [31:0] cap_wdata  = 32'h0;
    logic [3:0]  cap_wstrb  = 4'h0;
    logic [31:0] cap_araddr = 32'h0;
    int          aw_edge = 0;
    int          w_edge  = 0;

    axil_cmd_master #(
        .AXI_ADDR_WIDTH(32),
        .AXI_DATA_WIDTH(32),
        .FRAME_TIMEOUT (16)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .cmd_data_i    (cmd_data_i),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .rsp_data_o    (rsp_data_o),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .busy_o        (busy_o),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awprot  (m_axi_awprot),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Response sink readiness changes just after the rising edge; 0 = always ready, 1 = toggle, 2 = stalled.
    initial begin
        rsp_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       rsp_ready_i = 1'b1;
                1:       rsp_ready_i = ~rsp_ready_i;
                default: rsp_ready_i = 1'b0;
            endcase
        end
    end

    // AXI4-Lite slave evaluated on the falling edge; a handshake is recognised one
    // falling edge after the rising edge on which valid and ready were both high.
    logic        awv_prev = 1'b0, wv_prev = 1'b0, arv_prev = 1'b0;
    logic        bready_prev = 1'b0, rready_prev = 1'b0;
    logic [31:0] awaddr_prev = 32'h0, wdata_prev = 32'h0, araddr_prev = 32'h0;
    logic [3:0]  wstrb_prev = 4'h0;
    logic        aw_got = 1'b0, w_got = 1'b0, r_pend = 1'b0;
    int          aw_cnt = 0, w_cnt = 0, r_cnt = 0, edge_cnt = 0;

    initial begin
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = 32'h0;
        m_axi_rresp   = 2'b00;
    end

    always @(negedge clk) begin
        if (!rst_ni) begin
            m_axi_awready = 1'b0;
            m_axi_wready  = 1'b0;
            m_axi_bvalid  = 1'b0;
            m_axi_arready = 1'b0;
            m_axi_rvalid  = 1'b0;
            aw_got = 1'b0; w_got = 1'b0; r_pend = 1'b0;
            aw_cnt = 0; w_cnt = 0; r_cnt = 0;
            awv_prev = 1'b0; wv_prev = 1'b0; arv_prev = 1'b0;
            bready_prev = 1'b0; rready_prev = 1'b0;
        end else begin
            edge_cnt++;
            if (awv_prev && m_axi_awready) begin
                cap_awaddr    = awaddr_prev;
                aw_got        = 1'b1;
                m_axi_awready = 1'b0;
                aw_edge       = edge_cnt;
                check("awvalid_drop", m_axi_awvalid, 0);
            end else begin
                if (awv_prev) check("awvalid_hold", m_axi_awvalid, 1);
                if (m_axi_awvalid && !m_axi_awready && !aw_got) begin
                    if (aw_cnt >= aw_wait) begin m_axi_awready = 1'b1; aw_cnt = 0; end
                    else aw_cnt++;
                end
            end
            if (wv_prev && m_axi_wready) begin
                cap_wdata    = wdata_prev;
                cap_wstrb    = wstrb_prev;
                w_got        = 1'b1;
                m_axi_wready = 1'b0;
                w_edge       = edge_cnt;
                check("wvalid_drop", m_axi_wvalid, 0);
            end else begin
                if (wv_prev) check("wvalid_hold", m_axi_wvalid, 1);
                if (m_axi_wvalid && !m_axi_wready && !w_got) begin
                    if (w_cnt >= w_wait) begin m_axi_wready = 1'b1; w_cnt = 0; end
                    else w_cnt++;
                end
            end
            if (m_axi_bvalid && bready_prev) m_axi_bvalid = 1'b0;
            if (aw_got && w_got && !m_axi_bvalid) begin
                m_axi_bvalid = 1'b1;
                m_axi_bresp  = bresp_cfg;
                aw_got = 1'b0;
                w_got  = 1'b0;
            end
            if (arv_prev && m_axi_arready) begin
                cap_araddr    = araddr_prev;
                m_axi_arready = 1'b0;
                r_pend        = 1'b1;
                r_cnt         = 0;
            end else if (m_axi_arvalid && !m_axi_arready && !r_pend && !m_axi_rvalid) begin
                m_axi_arready = 1'b1;
            end
            if (m_axi_rvalid && rready_prev) m_axi_rvalid = 1'b0;
            if (r_pend) begin
                if (r_cnt >= r_wait) begin
                    m_axi_rvalid = 1'b1;
                    m_axi_rdata  = rdata_cfg;
                    m_axi_rresp  = rresp_cfg;
                    r_pend       = 1'b0;
                end else begin
                    r_cnt++;
                end
            end
            awv_prev = m_axi_awvalid; awaddr_prev = m_axi_awaddr;
            wv_prev  = m_axi_wvalid;  wdata_prev  = m_axi_wdata; wstrb_prev = m_axi_wstrb;
            arv_prev = m_axi_arvalid; araddr_prev = m_axi_araddr;
            bready_prev = m_axi_bready;
            rready_prev = m_axi_rready;
        end
    end

    // Response monitor: each accepted byte is popped from the scoreboard.
    logic       prev_pending = 1'b0;
    logic [7:0] prev_data = 8'h0;
    logic [7:0] exp_b;

    always @(negedge clk) begin
        if (!rst_ni) begin
            prev_pending = 1'b0;
        end else begin
            if (rsp_valid_o) check("cmd_ready_in_rsp", cmd_ready_o, 0);
            if (prev_pending) begin
                check("rsp_valid_hold", rsp_valid_o, 1);
                check("rsp_data_hold", rsp_data_o, prev_data);
            end
            if (rsp_valid_o && rsp_ready_i) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL rsp_unexpected observed=0x%02h expected=no byte", rsp_data_o);
                end
                if (exp_q.size() != 0) begin
                    exp_b = exp_q.pop_front();
                    check("rsp_byte", rsp_data_o, exp_b);
                    $display("rsp byte 0x%02h (expected 0x%02h)", rsp_data_o, exp_b);
                end
            end
            prev_pending = rsp_valid_o && !rsp_ready_i;
            prev_data    = rsp_data_o;
        end
    end

    // All stimulus tasks start and end on a falling edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        cmd_data_i  = b;
        cmd_valid_i = 1'b1;
        while (!cmd_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept", cmd_ready_o, 1);
        @(negedge clk);
        cmd_valid_i = 1'b0;
    endtask

    task automatic send_read(input logic [31:0] addr);
        send_byte(8'h01);
        for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
    endtask

    task automatic send_write(input logic [31:0] addr, input logic [31:0] data);
        send_byte(8'h02);
        for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
        for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8]);
    endtask

    task automatic push_read_rsp(input logic [1:0] resp, input logic [31:0] data);
        exp_q.push_back({4'hA, 2'b00, resp});
        for (int i = 0; i < 4; i++) exp_q.push_back(data[8*i +: 8]);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy_o) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue", exp_q.size(), 0);
        check("drain_idle", busy_o, 0);
    endtask

    initial begin
        int n;
        rst_ni      = 1'b0;
        cmd_data_i  = 8'h00;
        cmd_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready_o, 1);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_rsp_data", rsp_data_o, 8'h00);
        check("rst_busy", busy_o, 0);
        check("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 3'b000);
        check("rst_readies", {m_axi_bready, m_axi_rready}, 2'b00);
        check("fixed_prot", {m_axi_awprot, m_axi_arprot}, 6'b000000);
        check("fixed_wstrb", m_axi_wstrb, 4'hF);
        rst_ni = 1'b1;
        @(negedge clk);

        // READ with OKAY
        rdata_cfg = 32'hDEADBEEF; rresp_cfg = 2'b00;
        push_read_rsp(2'b00, 32'hDEADBEEF);
        send_read(32'h40000004);
        drain();
        check("rd_araddr", cap_araddr, 32'h40000004);
        $display("frame READ addr=0x40000004 done");

        // WRITE, awready three cycles behind wready
        aw_wait = 3; w_wait = 0; bresp_cfg = 2'b00;
        exp_q.push_back(8'hA0);
        send_write(32'h40000000, 32'h12345678);
        drain();
        check("wr_awaddr", cap_awaddr, 32'h40000000);
        check("wr_wdata", cap_wdata, 32'h12345678);
        check("wr_wstrb", cap_wstrb, 4'hF);
        check("wr_aw_after_w", aw_edge - w_edge, 3);
        aw_wait = 0;
        $display("frame WRITE addr=0x40000000 data=0x12345678 done");

        // READ to an unmapped address answered with DECERR
        rdata_cfg = 32'h0BADF00D; rresp_cfg = 2'b11;
        push_read_rsp(2'b11, 32'h0BADF00D);
        send_read(32'h00000000);
        drain();
        check("err_araddr", cap_araddr, 32'h00000000);
        $display("frame READ addr=0x00000000 DECERR done");

        // Unknown opcode with the response held off
        bp_mode = 2;
        exp_q.push_back(8'hEE);
        send_byte(8'h7F);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("badop_cmd_ready", cmd_ready_o, 0);
            check("badop_rsp_valid", rsp_valid_o, 1);
            check("badop_rsp_data", rsp_data_o, 8'hEE);
        end
        bp_mode = 0;
        drain();
        check("badop_cmd_ready_after", cmd_ready_o, 1);
        $display("frame opcode 0x7F done");

        // READ with a response sink that is ready every other cycle
        bp_mode = 1;
        rdata_cfg = 32'h89ABCDEF; rresp_cfg = 2'b00;
        push_read_rsp(2'b00, 32'h89ABCDEF);
        send_read(32'h40001000);
        drain();
        check("bp_araddr", cap_araddr, 32'h40001000);
        bp_mode = 0;
        $display("frame READ addr=0x40001000 backpressure done");

        // Partial frame dropped after 16 idle cycles
        send_byte(8'h01);
        send_byte(8'hAA);
        repeat (15) @(negedge clk);
        check("to_busy_at_15", busy_o, 1);
        @(negedge clk);
        check("to_busy_at_16", busy_o, 0);
        check("to_cmd_ready", cmd_ready_o, 1);
        repeat (4) @(negedge clk);
        check("to_no_rsp", rsp_valid_o, 0);
        rdata_cfg = 32'hCAFEF00D;
        push_read_rsp(2'b00, 32'hCAFEF00D);
        send_read(32'h40000008);
        drain();
        check("to_araddr", cap_araddr, 32'h40000008);
        $display("frame timeout then READ addr=0x40000008 done");

        // Reset while waiting for rvalid
        r_wait = 10;
        send_read(32'h40000010);
        n = 0;
        while (!m_axi_rready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_reached_r", m_axi_rready, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_rst_busy", busy_o, 0);
        check("async_rst_cmd_ready", cmd_ready_o, 1);
        check("async_rst_rready", m_axi_rready, 0);
        check("async_rst_rsp_valid", rsp_valid_o, 0);
        check("async_rst_rsp_data", rsp_data_o, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        r_wait = 0;
        @(negedge clk);
        rdata_cfg = 32'h55AA33CC;
        push_read_rsp(2'b00, 32'h55AA33CC);
        send_read(32'h40000010);
        drain();
        check("post_rst_araddr", cap_araddr, 32'h40000010);
        $display("frame reset then READ addr=0x40000010 done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
